// File: rtl/e_muldiv_unit.sv
// e_muldiv_unit: execute-stage iterative multiply/divide unit with HI/LO.
// Shift-add multiply and restoring divide, one step per cycle, followed by
// one sign-fixup cycle that writes HI/LO.
// Optional feature macro: EX_MD_EARLY_OUT_EN (multiply early termination).
// Ports:
//   i_clk, i_nrst       clock, synchronous active-low reset
//   i_valid             execute-stage instruction is not a bubble
//   i_con_mdop          op code (1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                       5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, others NOP)
//   i_data_a, i_data_b  forwarded rs / rt
//   i_con_flush         abort in-flight op
//   o_con_stall         hold upstream stages (combinational)
//   o_data_mfres        HI/LO for MFHI/MFLO (combinational)
//   o_con_busy          unit not idle
//   o_con_done          one-cycle pulse after a mul/div writes HI/LO
//   o_data_hi, o_data_lo architectural HI/LO
module e_muldiv_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_valid,
    input  logic [3:0]        i_con_mdop,
    input  logic [DATA_W-1:0] i_data_a,
    input  logic [DATA_W-1:0] i_data_b,
    input  logic              i_con_flush,
    output logic              o_con_stall,
    output logic [DATA_W-1:0] o_data_mfres,
    output logic              o_con_busy,
    output logic              o_con_done,
    output logic [DATA_W-1:0] o_data_hi,
    output logic [DATA_W-1:0] o_data_lo
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [PROD_W-1:0]   acc;        // product accumulator, filled from the top
    logic [DATA_W-1:0]   opb;        // multiplicand / divisor magnitude
    logic [DATA_W-1:0]   opq;        // multiplier, or dividend shifting into quotient
    logic [DATA_W-1:0]   rem;
    logic                sign_res;
    logic                sign_rem;
    logic                is_div;

    logic                md_op;
    logic                issue;
    logic                signed_op;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic [CNT_W-1:0]    cnt_dec;
    logic [DATA_W:0]     mul_sum;
    logic [PROD_W-1:0]   acc_step;
    logic [DATA_W-1:0]   opq_shr;
    logic                mul_last;
    logic [DATA_W:0]     rem_sh;
    logic                div_ge;
    logic [DATA_W-1:0]   rem_step;
    logic [DATA_W-1:0]   quo_step;
    logic [PROD_W-1:0]   prod;
    logic [PROD_W-1:0]   prod_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    // Issue/stall decode and the datapath for one mul/div step and the fixup
    always_comb begin
        md_op       = (i_con_mdop >= OP_MULT) && (i_con_mdop <= OP_MTLO);
        o_con_stall = o_con_busy && i_valid && md_op;
        issue       = i_valid && md_op && !o_con_stall && !i_con_flush;

        signed_op = (i_con_mdop == OP_MULT) || (i_con_mdop == OP_DIV);
        a_mag     = (signed_op && i_data_a[DATA_W-1]) ? -i_data_a : i_data_a;
        b_mag     = (signed_op && i_data_b[DATA_W-1]) ? -i_data_b : i_data_b;

        cnt_dec  = cnt - CNT_W'(1);
        // Carry out of the upper-half add becomes the new accumulator MSB
        mul_sum  = {1'b0, acc[PROD_W-1:DATA_W]} + (opq[0] ? {1'b0, opb} : '0);
        acc_step = {mul_sum, acc[DATA_W-1:1]};
        opq_shr  = opq >> 1;
`ifdef EX_MD_EARLY_OUT_EN
        mul_last = (cnt_dec == '0) || (opq_shr == '0);
`else
        mul_last = (cnt_dec == '0);
`endif

        rem_sh   = {rem, opq[DATA_W-1]};
        div_ge   = rem_sh >= {1'b0, opb};
        rem_step = div_ge ? (rem_sh[DATA_W-1:0] - opb) : rem_sh[DATA_W-1:0];
        quo_step = {opq[DATA_W-2:0], div_ge};

`ifdef EX_MD_EARLY_OUT_EN
        // Early exit leaves the partial product cnt places too high
        prod = acc >> cnt;
`else
        prod = acc;
`endif
        prod_fix = sign_res ? -prod : prod;
        // Divide by zero keeps the all-ones quotient; remainder fixup restores the dividend
        quo_fix  = (sign_res && (opb != '0)) ? -opq : opq;
        rem_fix  = sign_rem ? -rem : rem;

        o_data_mfres = '0;
        if (i_valid && (i_con_mdop == OP_MFHI)) begin
            o_data_mfres = o_data_hi;
        end else if (i_valid && (i_con_mdop == OP_MFLO)) begin
            o_data_mfres = o_data_lo;
        end
    end

    // Control FSM, iteration registers and HI/LO
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            acc        <= '0;
            opb        <= '0;
            opq        <= '0;
            rem        <= '0;
            sign_res   <= 1'b0;
            sign_rem   <= 1'b0;
            is_div     <= 1'b0;
            o_con_busy <= 1'b0;
            o_con_done <= 1'b0;
            o_data_hi  <= '0;
            o_data_lo  <= '0;
        end else begin
            o_con_done <= 1'b0;
            if (i_con_flush) begin
                state      <= S_IDLE;
                o_con_busy <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (issue) begin
                            case (i_con_mdop)
                                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                    is_div     <= (i_con_mdop == OP_DIV) || (i_con_mdop == OP_DIVU);
                                    acc        <= '0;
                                    rem        <= '0;
                                    opq        <= (i_con_mdop == OP_DIV || i_con_mdop == OP_DIVU) ? a_mag : b_mag;
                                    opb        <= (i_con_mdop == OP_DIV || i_con_mdop == OP_DIVU) ? b_mag : a_mag;
                                    sign_res   <= signed_op && (i_data_a[DATA_W-1] ^ i_data_b[DATA_W-1]);
                                    sign_rem   <= signed_op && i_data_a[DATA_W-1];
                                    cnt        <= CNT_W'(DATA_W);
                                    o_con_busy <= 1'b1;
                                    state      <= (i_con_mdop == OP_DIV || i_con_mdop == OP_DIVU) ? S_DIV : S_MUL;
                                end
                                OP_MTHI: o_data_hi <= i_data_a;
                                OP_MTLO: o_data_lo <= i_data_a;
                                default: ;
                            endcase
                        end
                    end
                    S_MUL: begin
                        acc <= acc_step;
                        opq <= opq_shr;
                        cnt <= cnt_dec;
                        if (mul_last) begin
                            state <= S_FIX;
                        end
                    end
                    S_DIV: begin
                        rem <= rem_step;
                        opq <= quo_step;
                        cnt <= cnt_dec;
                        if (cnt_dec == '0) begin
                            state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        if (is_div) begin
                            o_data_hi <= rem_fix;
                            o_data_lo <= quo_fix;
                        end else begin
                            o_data_hi <= prod_fix[PROD_W-1:DATA_W];
                            o_data_lo <= prod_fix[DATA_W-1:0];
                        end
                        o_con_done <= 1'b1;
                        o_con_busy <= 1'b0;
                        state      <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Self-checking bench for e_muldiv_unit: directed corner cases plus random
// mul/div/MT/MF traffic against an arithmetic reference model of HI/LO.
module tb_e_muldiv_unit;

    localparam int unsigned W = 32;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic         clk;
    logic         nrst;
    logic         valid;
    logic [3:0]   mdop;
    logic [W-1:0] da;
    logic [W-1:0] db;
    logic         flush;
    logic         stall;
    logic [W-1:0] mfres;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks;
    int n_errors;
    logic [W-1:0] model_hi;
    logic [W-1:0] model_lo;

    e_muldiv_unit #(.DATA_W(W)) dut (
        .i_clk        (clk),
        .i_nrst       (nrst),
        .i_valid      (valid),
        .i_con_mdop   (mdop),
        .i_data_a     (da),
        .i_data_b     (db),
        .i_con_flush  (flush),
        .o_con_stall  (stall),
        .o_data_mfres (mfres),
        .o_con_busy   (busy),
        .o_con_done   (done),
        .o_data_hi    (hi),
        .o_data_lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference HI/LO from plain arithmetic on the operands
    task automatic calc(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] rh, output logic [W-1:0] rl);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rh = '0;
        rl = '0;
        case (op)
            OP_MULT: begin
                p  = 64'(sa * sb);
                rh = p[63:32];
                rl = p[31:0];
            end
            OP_MULTU: begin
                p  = {32'h0, a} * {32'h0, b};
                rh = p[63:32];
                rl = p[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (b == '0) begin
                    rh = a;
                    rl = '1;
                end else if (op == OP_DIV) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    rl = 32'(q);
                    rh = 32'(r);
                end else begin
                    rl = a / b;
                    rh = a % b;
                end
            end
            default: ;
        endcase
    endtask

    // Cycle (issue = 0) in which done and the new HI/LO appear
    function automatic int exp_cycles(input logic [3:0] op, input logic [W-1:0] b);
        int k;
        logic [W-1:0] mag;
        k = W;
`ifdef EX_MD_EARLY_OUT_EN
        if (op == OP_MULT || op == OP_MULTU) begin
            mag = (op == OP_MULT && b[W-1]) ? -b : b;
            k = 1;
            for (int i = 0; i < W; i++) begin
                if (mag[i]) k = i + 1;
            end
        end
`else
        mag = b;
        if (op == OP_MULT && mag == '0) k = W;
`endif
        return k + 2;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        valid = 1'b1;
        mdop  = op;
        da    = a;
        db    = b;
        step();
        valid = 1'b0;
        mdop  = OP_NOP;
    endtask

    // mode 0: plain, 1: non-MD ops probed in cycle 1, 2: dependent MFLO from cycle 1
    task automatic do_md(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
        logic [W-1:0] eh;
        logic [W-1:0] el;
        int ec;
        int got;
        int nst;
        calc(op, a, b, eh, el);
        ec  = exp_cycles(op, b);
        got = 0;
        nst = 0;
        issue(op, a, b);
        check("busy_c1", 64'(busy), 64'(1));
        if (mode == 1) begin
            valid = 1'b1;
            mdop  = OP_NOP;
            #1;
            check("alu_nostall", 64'(stall), 64'(0));
            mdop = 4'd12;
            #1;
            check("nop12_nostall", 64'(stall), 64'(0));
            mdop = OP_MTHI;
            #1;
            check("dep_stall", 64'(stall), 64'(1));
            valid = 1'b0;
            mdop  = OP_NOP;
        end
        if (mode == 2) begin
            valid = 1'b1;
            mdop  = OP_MFLO;
            #1;
            for (int c = 1; c <= 80; c++) begin
                if (!stall) begin
                    got = c;
                    break;
                end
                nst++;
                step();
            end
            check("stall_cycles", 64'(nst), 64'(ec - 1));
            check("mflo_after_stall", 64'(mfres), 64'(el));
            check("done_at_release", 64'(done), 64'(1));
            valid = 1'b0;
            mdop  = OP_NOP;
        end else begin
            for (int c = 1; c <= 80; c++) begin
                if (done) begin
                    got = c;
                    break;
                end
                step();
            end
        end
        check("done_cycle", 64'(got), 64'(ec));
        check("hi", 64'(hi), 64'(eh));
        check("lo", 64'(lo), 64'(el));
        step();
        check("done_pulse", 64'(done), 64'(0));
        model_hi = eh;
        model_lo = el;
    endtask

    task automatic mt(input logic [3:0] op, input logic [W-1:0] v);
        issue(op, v, '0);
        if (op == OP_MTHI) model_hi = v;
        else model_lo = v;
    endtask

    task automatic mf_check();
        valid = 1'b1;
        mdop  = OP_MFHI;
        #1;
        check("mfhi", 64'(mfres), 64'(model_hi));
        mdop = OP_MFLO;
        #1;
        check("mflo", 64'(mfres), 64'(model_lo));
        valid = 1'b0;
        mdop  = OP_NOP;
    endtask

    initial begin
        int ndone;
        int kind;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_checks = 0;
        n_errors = 0;
        model_hi = '0;
        model_lo = '0;
        flush = 1'b0;
        nrst  = 1'b0;
        valid = 1'b1;
        mdop  = OP_MULT;
        da    = 32'd5;
        db    = 32'd5;
        step();
        step();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_stall", 64'(stall), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        mdop = OP_MFHI;
        #1;
        check("rst_mfres", 64'(mfres), 64'(0));
        valid = 1'b0;
        mdop  = OP_NOP;
        nrst  = 1'b1;
        step();

        // Directed corner cases
        do_md(OP_MULT,  32'hFFFFFFFD, 32'd7, 0);
        do_md(OP_DIVU,  32'd100, 32'd7, 0);
        do_md(OP_DIV,   32'hFFFFFFF9, 32'd2, 0);
        do_md(OP_DIV,   32'd5, 32'd0, 0);
        do_md(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 0);
        do_md(OP_DIV,   32'hFFFFFFF9, 32'd0, 0);
        do_md(OP_MULTU, 32'h12345678, 32'd3, 0);
        do_md(OP_MULTU, 32'hFFFFFFFF, 32'h80000000, 0);
        do_md(OP_MULT,  32'h80000000, 32'h80000000, 0);
        do_md(OP_MULT,  32'h1234, 32'd0, 0);
        do_md(OP_MULT,  32'h0000BEEF, 32'hFFFFFF00, 1);
        do_md(OP_MULT,  32'hDEADBEEF, 32'h00012345, 2);
        mf_check();

        // MT then MF next cycle
        mt(OP_MTHI, 32'h01234567);
        mf_check();
        mt(OP_MTLO, 32'h89ABCDEF);
        mf_check();

        // Flush in cycle 10 of a divide
        mt(OP_MTHI, 32'hA5A5A5A5);
        issue(OP_DIVU, 32'd9, 32'd3);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_hi", 64'(hi), 64'(32'hA5A5A5A5));
        check("flush_lo", 64'(lo), 64'(model_lo));
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) ndone++;
            step();
        end
        check("flush_nodone", 64'(ndone), 64'(0));
        check("flush_hi_late", 64'(hi), 64'(32'hA5A5A5A5));

        // Flush beats a same-cycle issue
        valid = 1'b1;
        mdop  = OP_MULT;
        da    = 32'd3;
        db    = 32'd3;
        flush = 1'b1;
        step();
        check("flush_issue_busy", 64'(busy), 64'(0));
        mdop = OP_MTHI;
        da   = 32'h5555AAAA;
        step();
        valid = 1'b0;
        mdop  = OP_NOP;
        flush = 1'b0;
        check("flush_mt_hi", 64'(hi), 64'(32'hA5A5A5A5));

        // Reset in cycle 10 of a divide
        issue(OP_DIVU, 32'd9, 32'd3);
        repeat (9) step();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        check("rst_mid_hi", 64'(hi), 64'(0));
        check("rst_mid_lo", 64'(lo), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_done", 64'(done), 64'(0));
        model_hi = '0;
        model_lo = '0;
        step();

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 5));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            if ($urandom_range(0, 3) == 0) ra = W'($urandom_range(0, 300));
            if (kind <= 3) begin
                do_md(4'(kind + 1), ra, rb, 0);
            end else if (kind == 4) begin
                mt(($urandom_range(0, 1) == 0) ? OP_MTHI : OP_MTLO, ra);
                mf_check();
            end else begin
                mf_check();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
